// File: rtl/vec_unpack_pkg.sv
// Shared types and helpers for the vector load unpacker.
// Covers element width decode, vl clamping and the word-count rule.
package vec_unpack_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned LANE_W   = 32;
    localparam int unsigned VL_MAX_8 = 16;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2
    } sew_e;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } unpack_state_e;

    // Encoding 3 is folded into 32b.
    function automatic sew_e decode_sew(input logic [1:0] sew);
        case (sew)
            2'd0:    return SEW_8;
            2'd1:    return SEW_16;
            default: return SEW_32;
        endcase
    endfunction

    function automatic logic [4:0] clamp_vl(input sew_e sew, input logic [4:0] vl);
        logic [4:0] max_vl;
        case (sew)
            SEW_8:   max_vl = 5'(VL_MAX_8);
            SEW_16:  max_vl = 5'(VL_MAX_8 / 2);
            default: max_vl = 5'(VL_MAX_8 / 4);
        endcase
        return (vl > max_vl) ? max_vl : vl;
    endfunction

    // Index of the final memory word; only meaningful for a nonzero clamped vl.
    function automatic logic [1:0] last_word(input sew_e sew, input logic [4:0] vl);
        logic [4:0] vl_m1;
        vl_m1 = vl - 5'd1;
        case (sew)
            SEW_8:   return 2'(vl_m1 >> 2);
            SEW_16:  return 2'(vl_m1 >> 1);
            default: return 2'(vl_m1);
        endcase
    endfunction

endpackage

// File: rtl/word_scatter.sv
// Places one memory-format word into its arithmetic-format lanes and slots,
// producing only the bytes of elements below vl.
module word_scatter
    import vec_unpack_pkg::*;
(
    input  logic [LANE_W-1:0]         word_i,
    input  logic [1:0]                w_i,
    input  sew_e                      sew_i,
    input  logic [4:0]                vl_eff_i,
    output logic [LANES*LANE_W-1:0]   data_o,
    output logic [LANES*LANE_W/8-1:0] be_o
);

    always_comb begin
        data_o = '0;
        be_o   = '0;
        case (sew_i)
            SEW_8: begin
                // Element 4w+j lands in lane j, byte slot w.
                for (int j = 0; j < 4; j++) begin
                    if ({1'b0, w_i, 2'(j)} < vl_eff_i) begin
                        data_o[j*32 + int'(w_i)*8 +: 8] = word_i[j*8 +: 8];
                        be_o[j*4 + int'(w_i)]           = 1'b1;
                    end
                end
            end
            SEW_16: begin
                // Element 2w+k lands in lane (2w+k)%4, halfword slot w/2.
                for (int k = 0; k < 2; k++) begin
                    if (5'(2*int'(w_i) + k) < vl_eff_i) begin
                        data_o[((2*int'(w_i) + k) % 4)*32 + (int'(w_i) / 2)*16 +: 16] =
                            word_i[k*16 +: 16];
                        be_o[((2*int'(w_i) + k) % 4)*4 + (int'(w_i) / 2)*2 +: 2] = 2'b11;
                    end
                end
            end
            default: begin
                if ({3'b000, w_i} < vl_eff_i) begin
                    data_o[int'(w_i)*32 +: 32] = word_i;
                    be_o[int'(w_i)*4 +: 4]     = 4'hF;
                end
            end
        endcase
    end

endmodule

// File: rtl/vec_load_unpack.sv
// Sequential memory-to-arithmetic unpacker: collects up to four 32-bit words
// into one 128-bit vector with byte enables, then holds it until accepted.
module vec_load_unpack
    import vec_unpack_pkg::*;
(
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      start_i,
    input  logic [1:0]                sew_i,
    input  logic [4:0]                vl_i,
    input  logic [LANE_W-1:0]         mem_data_i,
    input  logic                      mem_valid_i,
    output logic                      mem_ready_o,
    output logic [LANES*LANE_W-1:0]   arith_data_o,
    output logic [LANES*LANE_W/8-1:0] arith_be_o,
    output logic                      arith_valid_o,
    input  logic                      arith_ready_i,
    output logic                      busy_o
);

    localparam int unsigned VecW = LANES * LANE_W;
    localparam int unsigned BeW  = VecW / 8;

    unpack_state_e    state_q, state_d;
    sew_e             sew_q, sew_d;
    logic [4:0]       vl_q, vl_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       w_q, w_d;
    logic [VecW-1:0]  buf_q, buf_d;
    logic [BeW-1:0]   be_q, be_d;

    sew_e             sew_start;
    logic [4:0]       vl_start;
    logic [VecW-1:0]  scat_data;
    logic [BeW-1:0]   scat_be;

    assign sew_start = decode_sew(sew_i);
    assign vl_start  = clamp_vl(sew_start, vl_i);

    word_scatter u_word_scatter (
        .word_i   (mem_data_i),
        .w_i      (w_q),
        .sew_i    (sew_q),
        .vl_eff_i (vl_q),
        .data_o   (scat_data),
        .be_o     (scat_be)
    );

    always_comb begin
        state_d = state_q;
        sew_d   = sew_q;
        vl_d    = vl_q;
        last_d  = last_q;
        w_d     = w_q;
        buf_d   = buf_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sew_d   = sew_start;
                    vl_d    = vl_start;
                    last_d  = (vl_start == 5'd0) ? 2'd0 : last_word(sew_start, vl_start);
                    w_d     = 2'd0;
                    buf_d   = '0;
                    be_d    = '0;
                    state_d = (vl_start == 5'd0) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (mem_valid_i) begin
                    buf_d = buf_q | scat_data;
                    be_d  = be_q | scat_be;
                    if (w_q == last_q) begin
                        state_d = HOLD;
                    end else begin
                        w_d = w_q + 2'd1;
                    end
                end
            end
            HOLD: begin
                // A start in the handshake cycle is dropped: IDLE is not yet reached.
                if (arith_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            sew_q   <= SEW_8;
            vl_q    <= 5'd0;
            last_q  <= 2'd0;
            w_q     <= 2'd0;
            buf_q   <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            last_q  <= last_d;
            w_q     <= w_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
        end
    end

    assign mem_ready_o   = (state_q == FILL);
    assign arith_valid_o = (state_q == HOLD);
    assign busy_o        = (state_q != IDLE);
    assign arith_data_o  = buf_q;
    assign arith_be_o    = be_q;

endmodule
